// File: rtl/tick_gen.sv
// Periodic tick generator: emits one-clock ticks every period_reg enabled clocks,
// either continuously or for a fixed burst, followed by a one-clock done pulse.
module tick_gen #(
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [7:0]       burst_len,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [7:0]       left_q, left_d;
  logic             last_q, last_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= WIDTH'(DEFAULT_PERIOD);
      left_q   <= '0;
      last_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      left_q   <= left_d;
      last_q   <= last_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    left_d   = left_q;
    last_d   = last_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          period_d = (period_in == '0) ? WIDTH'(1) : period_in;
        end
        if (start && !stop) begin
          state_d = RUN;
          count_d = '0;
          left_d  = burst_len;
          last_d  = 1'b0;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
          last_d  = 1'b0;
        // last_q marks the cycle in which the final burst tick is visible;
        // DONE follows it so done lands one clock after that tick.
        end else if (last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          count_d = '0;
          last_d  = 1'b0;
        end else if (enable) begin
          if (count_q == period_q - WIDTH'(1)) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (left_q != 8'd0) begin
              left_d = left_q - 8'd1;
              last_d = (left_q == 8'd1);
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: directed runs push expected tick/done cycles,
// a negedge monitor pops and compares each pulse the DUT produces.
module tb_tick_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        load = 1'b0;
  logic [15:0] period_in = '0;
  logic [7:0]  burst_len = '0;
  logic        tick, busy, done;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int cyc;
    bit is_done;
  } exp_t;
  exp_t exp_q[$];

  tick_gen #(.WIDTH(16), .DEFAULT_PERIOD(100)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
    .load(load), .period_in(period_in), .burst_len(burst_len),
    .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every tick/done pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (mon_en && (tick !== 1'b0 || done !== 1'b0)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse cyc=%0d got tick=%b done=%b required no pulse", cyc, tick, done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || done !== e.is_done || tick !== !e.is_done) begin
          n_err++;
          $display("FAIL pulse got cyc=%0d tick=%b done=%b required cyc=%0d %s",
                   cyc, tick, done, e.cyc, e.is_done ? "done" : "tick");
        end else begin
          $display("pulse ok cyc=%0d %s", cyc, e.is_done ? "done" : "tick");
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, req);
    end else begin
      $display("check ok %s cyc=%0d value=%b", name, cyc, got);
    end
  endtask

  task automatic expect_ev(input int c, input bit d);
    exp_t e;
    e.cyc = c;
    e.is_done = d;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input int p);
    load = 1'b1;
    period_in = p[15:0];
    step();
    load = 1'b0;
  endtask

  task automatic go(input int b, output int e);
    burst_len = b[7:0];
    start = 1'b1;
    step();
    e = cyc;
    start = 1'b0;
  endtask

  task automatic halt(input string name);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk(name, busy, 1'b0);
  endtask

  initial begin
    int e;

    // Reset state
    step(3);
    chk("rst_tick", tick, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b1;
    mon_en = 1'b1;
    enable = 1'b1;
    step(10);

    // Default period, continuous
    go(0, e);
    for (int k = 1; k <= 3; k++) expect_ev(e + 100 * k, 1'b0);
    chk("cont_busy_start", busy, 1'b1);
    step(150);
    chk("cont_busy_mid", busy, 1'b1);
    step(156);
    chk("cont_busy_late", busy, 1'b1);
    halt("cont_stop_busy");

    // Burst of 3 at period 4
    do_load(4);
    go(3, e);
    expect_ev(e + 4, 1'b0);
    expect_ev(e + 8, 1'b0);
    expect_ev(e + 12, 1'b0);
    expect_ev(e + 13, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      step();
      chk($sformatf("burst_busy_%0d", i), busy, (i <= 12) ? 1'b1 : 1'b0);
    end

    // Enable gating at period 5: three frozen clocks delay the tick by 3
    do_load(5);
    go(0, e);
    expect_ev(e + 8, 1'b0);
    expect_ev(e + 13, 1'b0);
    step(2);
    enable = 1'b0;
    step(3);
    chk("gate_busy", busy, 1'b1);
    enable = 1'b1;
    step(9);
    halt("gate_stop_busy");

    // Stop colliding with a due tick, then restart from count 0
    go(0, e);
    step(4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("coll_busy", busy, 1'b0);
    chk("coll_tick", tick, 1'b0);
    chk("coll_done", done, 1'b0);
    step(3);
    go(0, e);
    expect_ev(e + 5, 1'b0);
    step(7);
    halt("restart_stop_busy");

    // period_in = 0 acts as period 1
    do_load(0);
    go(4, e);
    for (int k = 1; k <= 4; k++) expect_ev(e + k, 1'b0);
    expect_ev(e + 5, 1'b1);
    step(7);

    // Load during RUN is ignored
    do_load(3);
    go(2, e);
    expect_ev(e + 3, 1'b0);
    expect_ev(e + 6, 1'b0);
    expect_ev(e + 7, 1'b1);
    step(1);
    load = 1'b1;
    period_in = 16'd7;
    step();
    load = 1'b0;
    step(8);
    chk("runload_busy_end", busy, 1'b0);

    // Start with stop in IDLE stays idle
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", busy, 1'b0);
    step(5);
    chk("ss_busy_later", busy, 1'b0);

    // Reset mid-burst with two ticks left
    do_load(4);
    go(3, e);
    expect_ev(e + 4, 1'b0);
    step(5);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_tick", tick, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    step(10);
    // Period must be back to the reset default of 100
    go(1, e);
    expect_ev(e + 100, 1'b0);
    expect_ev(e + 101, 1'b1);
    step(103);
    chk("final_busy", busy, 1'b0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events got=%0d required=0 (next cyc=%0d)", exp_q.size(), exp_q[0].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
